keypad_encoder: RTL

Scans a 4x4 matrix keypad, debounces it, and encodes the single pressed key into the 4-bit code `A,B,C,D`. This is the input end of the display path: the code feeds the 7-segment decoder directly. A one-cycle `valid` pulse marks each accepted new press.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_scanner.sv | 33 +++
 rtl/keypad_encoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad encoder.
package keypad_pkg;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {IDLE, DEB_P, HELD, DEB_R} state_t;
  typedef enum logic [1:0] {NONE, KEY, MULTI} frame_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Index of the set bit in a one-hot nibble (0 when none is set).
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: divider, one-hot column rotation, sample and frame-end strobes.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample,
  output logic       frame_end
);
  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div;

  assign sample    = (div == DW'(SCAN_DIV - 1));
  assign frame_end = sample && col[3];
  assign col_idx   = onehot_idx(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      col <= 4'b0001;
    end else if (sample) begin
      div <= '0;
      col <= {col[2:0], col[3]};
    end else begin
      div <= div + 1'b1;
    end
  end
endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad encoder: per-frame key classification, debounce FSM and code outputs.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       valid,
  output logic       pressed
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic              sample, frame_end;
  logic [1:0]        col_idx;
  logic [1:0]        acc_hits;
  logic [CODE_W-1:0] acc_code;
  logic [2:0]        row_hits, tot_hits;
  logic [1:0]        hits_sat;
  logic [CODE_W-1:0] frame_code;
  frame_t            frame_res;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] code;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .col_idx   (col_idx),
    .sample    (sample),
    .frame_end (frame_end)
  );

  // Frame result includes the current sample so the FSM can act on the frame-end edge.
  always_comb begin
    row_hits   = popcount4(row);
    tot_hits   = {1'b0, acc_hits} + row_hits;
    hits_sat   = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
    frame_code = (acc_hits == 2'd0 && row_hits == 3'd1) ? {onehot_idx(row), col_idx} : acc_code;
    frame_res  = (tot_hits == 3'd0) ? NONE : (tot_hits == 3'd1) ? KEY : MULTI;
    cnt_inc    = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hits <= 2'd0;
      acc_code <= '0;
    end else if (sample) begin
      acc_hits <= frame_end ? 2'd0 : hits_sat;
      acc_code <= frame_end ? '0 : frame_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cand    <= '0;
      code    <= '0;
      valid   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: if (frame_res == KEY) begin
            cand <= frame_code;
            cnt  <= CW'(1);
            if (DEBOUNCE == 1) begin
              state   <= HELD;
              code    <= frame_code;
              valid   <= 1'b1;
              pressed <= 1'b1;
            end else begin
              state <= DEB_P;
            end
          end
          DEB_P: begin
            if (frame_res == KEY && frame_code == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == CW'(DEBOUNCE)) begin
                state   <= HELD;
                code    <= cand;
                valid   <= 1'b1;
                pressed <= 1'b1;
              end
            end else if (frame_res == KEY) begin
              cand <= frame_code;
              cnt  <= CW'(1);
            end else begin
              state <= IDLE;
            end
          end
          HELD: if (frame_res == NONE) begin
            cnt <= CW'(1);
            if (DEBOUNCE == 1) begin
              state   <= IDLE;
              pressed <= 1'b0;
            end else begin
              state <= DEB_R;
            end
          end
          DEB_R: begin
            if (frame_res == NONE) begin
              cnt <= cnt_inc;
              if (cnt_inc == CW'(DEBOUNCE)) begin
                state   <= IDLE;
                pressed <= 1'b0;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign {A, B, C, D} = code;
endmodule
